// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding and
// register/instruction constants used by the hazard and forwarding logic.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_STALL    = 2'd3
  } state_t;

  localparam logic [4:0]  REG_X0    = 5'd0;
  // addi x0, x0, 0 -- what a flushed pipeline register reads as
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Bus between the EX/ID hazard sources and the hazard/flush sequencer.
// The master drives hazard inputs; the slave (sequencer) drives pipeline controls.
interface hazard_flush_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic            ex_valid;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pc_sel;
  logic [XLEN-1:0]  redirect_pc;
  logic             busy;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_valid, br_taken, br_target, ex_mem_read, ex_rd, id_rs1, id_rs2,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pc_sel, redirect_pc,
           busy, flush_cnt, stall_cnt
  );

  modport slave (
    input  ex_valid, br_taken, br_target, ex_mem_read, ex_rd, id_rs1, id_rs2,
    output pc_write, ifid_write, ifid_flush, idex_flush, pc_sel, redirect_pc,
           busy, flush_cnt, stall_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags an ID instruction that reads
// the destination of a load still in EX. Shared with the forwarding unit.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  output logic       o_hit
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign o_hit = i_ex_valid & i_ex_mem_read & (i_ex_rd != REG_X0) &
                 ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush sequencer: taken-branch redirect + flush, load-use bubble.
// Optional HAZ_STATS_EN macro builds saturating redirect/stall event counters.
module hazard_flush_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hazard_flush_ctrl_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] CNT_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_t          r_state;
  state_t          w_nextState;
  logic [FC_W-1:0] r_cnt;
  logic [XLEN-1:0] r_redirectPc;

  logic w_hit;
  logic w_branch;
  logic w_accept;
  logic w_pcWrite;
  logic w_ifidWrite;
  logic w_ifidFlush;
  logic w_idexFlush;
  logic w_pcSel;

  load_use_detect u_loadUse (
    .i_ex_valid    (bus.ex_valid),
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_rd       (bus.ex_rd),
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .o_hit         (w_hit)
  );

  assign w_branch = bus.ex_valid & bus.br_taken;
  // RUN and STALL both evaluate new hazards; REDIRECT/FLUSH are wrong-path cycles
  assign w_accept = (r_state == ST_RUN) | (r_state == ST_STALL);

  always_comb begin
    w_nextState = r_state;
    w_pcWrite   = 1'b1;
    w_ifidWrite = 1'b1;
    w_ifidFlush = 1'b0;
    w_idexFlush = 1'b0;
    w_pcSel     = 1'b0;
    case (r_state)
      ST_RUN, ST_STALL: begin
        if (w_branch) begin
          w_nextState = ST_REDIRECT;
        end else if (w_hit) begin
          w_nextState = ST_STALL;
          // Mealy stall is suppressed while reset is held so outputs keep reset values
          if (reset_n) begin
            w_pcWrite   = 1'b0;
            w_ifidWrite = 1'b0;
            w_idexFlush = 1'b1;
          end
        end else begin
          w_nextState = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        w_pcSel     = 1'b1;
        w_ifidFlush = 1'b1;
        w_idexFlush = 1'b1;
        w_nextState = (CNT_LOAD == '0) ? ST_RUN : ST_FLUSH;
      end
      ST_FLUSH: begin
        w_ifidFlush = 1'b1;
        w_idexFlush = 1'b1;
        if (r_cnt == FC_W'(1)) w_nextState = ST_RUN;
      end
      default: w_nextState = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      r_redirectPc <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_REDIRECT) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == ST_FLUSH && r_cnt != '0) begin
        r_cnt <= r_cnt - FC_W'(1);
      end
      if (w_accept && w_branch) r_redirectPc <= bus.br_target;
    end
  end

  assign bus.pc_write    = w_pcWrite;
  assign bus.ifid_write  = w_ifidWrite;
  assign bus.ifid_flush  = w_ifidFlush;
  assign bus.idex_flush  = w_idexFlush;
  assign bus.pc_sel      = w_pcSel;
  assign bus.redirect_pc = r_redirectPc;
  assign bus.busy        = (r_state != ST_RUN);

`ifdef HAZ_STATS_EN
  logic [CNT_W-1:0] r_flushCnt;
  logic [CNT_W-1:0] r_stallCnt;

  // Every REDIRECT/STALL entry counts, including back-to-back stalls; both saturate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flushCnt <= '0;
      r_stallCnt <= '0;
    end else begin
      if (w_nextState == ST_REDIRECT && r_flushCnt != '1) r_flushCnt <= r_flushCnt + CNT_W'(1);
      if (w_nextState == ST_STALL && r_stallCnt != '1) r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  assign bus.flush_cnt = r_flushCnt;
  assign bus.stall_cnt = r_stallCnt;
`else
  assign bus.flush_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: directed scenarios then random traffic,
// checked against a cycle-level model of flush windows and bubbles.
module tb_hazard_flush_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  hazard_flush_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  hazard_flush_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string           tag;
    logic            pcWrite;
    logic            ifidWrite;
    logic            ifidFlush;
    logic            idexFlush;
    logic            pcSel;
    logic            busy;
    logic [XLEN-1:0] redirectPc;
    logic [CNT_W-1:0] flushCnt;
    logic [CNT_W-1:0] stallCnt;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: remaining flush cycles, pending bubble, latched target, event counts
  int              flushLeft   = 0;
  bit              stallBubble = 0;
  logic [XLEN-1:0] mTarget     = '0;
  int              mFlushCnt   = 0;
  int              mStallCnt   = 0;
  bit              statsOn;

  function automatic int satInc(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic resetModel();
    flushLeft   = 0;
    stallBubble = 0;
    mTarget     = '0;
    mFlushCnt   = 0;
    mStallCnt   = 0;
  endtask

  task automatic checkField(input string tag, input string name,
                            input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", tag, name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField(e.tag, "pc_write",    XLEN'(bus.pc_write),   XLEN'(e.pcWrite));
    checkField(e.tag, "ifid_write",  XLEN'(bus.ifid_write), XLEN'(e.ifidWrite));
    checkField(e.tag, "ifid_flush",  XLEN'(bus.ifid_flush), XLEN'(e.ifidFlush));
    checkField(e.tag, "idex_flush",  XLEN'(bus.idex_flush), XLEN'(e.idexFlush));
    checkField(e.tag, "pc_sel",      XLEN'(bus.pc_sel),     XLEN'(e.pcSel));
    checkField(e.tag, "busy",        XLEN'(bus.busy),       XLEN'(e.busy));
    checkField(e.tag, "redirect_pc", bus.redirect_pc,       e.redirectPc);
    checkField(e.tag, "flush_cnt",   XLEN'(bus.flush_cnt),  XLEN'(e.flushCnt));
    checkField(e.tag, "stall_cnt",   XLEN'(bus.stall_cnt),  XLEN'(e.stallCnt));
  endtask

  task automatic checkReset(input string tag);
    exp_t e;
    e.tag = tag; e.pcWrite = 1'b1; e.ifidWrite = 1'b1; e.ifidFlush = 1'b0;
    e.idexFlush = 1'b0; e.pcSel = 1'b0; e.busy = 1'b0; e.redirectPc = '0;
    e.flushCnt = '0; e.stallCnt = '0;
    checkOutput(e);
  endtask

  // Drive one cycle of inputs and queue what the pipeline controls must look like this cycle
  task automatic applyStimulus(input string tag, input bit v, input bit bt,
                               input logic [XLEN-1:0] tgt, input bit mr,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2);
    exp_t e;
    bit   branch;
    bit   hit;
    @(negedge clk);
    bus.ex_valid    = v;
    bus.br_taken    = bt;
    bus.br_target   = tgt;
    bus.ex_mem_read = mr;
    bus.ex_rd       = rd;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;

    e.tag = tag; e.pcWrite = 1'b1; e.ifidWrite = 1'b1; e.ifidFlush = 1'b0;
    e.idexFlush = 1'b0; e.pcSel = 1'b0; e.busy = 1'b0;
    e.redirectPc = mTarget;
    e.flushCnt = statsOn ? CNT_W'(mFlushCnt) : '0;
    e.stallCnt = statsOn ? CNT_W'(mStallCnt) : '0;

    if (flushLeft > 0) begin
      e.ifidFlush = 1'b1;
      e.idexFlush = 1'b1;
      e.pcSel     = (flushLeft == FLUSH_CYCLES);
      e.busy      = 1'b1;
      flushLeft--;
    end else begin
      branch = v && bt;
      hit    = v && mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
      e.busy      = stallBubble;
      stallBubble = 1'b0;
      if (branch) begin
        flushLeft = FLUSH_CYCLES;
        mTarget   = tgt;
        mFlushCnt = satInc(mFlushCnt);
      end else if (hit) begin
        e.pcWrite   = 1'b0;
        e.ifidWrite = 1'b0;
        e.idexFlush = 1'b1;
        stallBubble = 1'b1;
        mStallCnt   = satInc(mStallCnt);
      end
    end
    expQ.push_back(e);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        me = expQ.pop_front();
        checkOutput(me);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [XLEN-1:0] rTgt;
`ifdef HAZ_STATS_EN
    statsOn = 1'b1;
`else
    statsOn = 1'b0;
`endif
    bus.ex_valid = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.ex_mem_read = 1'b0; bus.ex_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    #3;
    checkReset("por");
    #20;
    @(posedge clk); #3;
    reset_n = 1'b1;
    resetModel();

    applyStimulus("t1_branch", 1, 1, 32'h0000_0040, 0, 5'd0, 5'd0, 5'd0);
    idle("t1_redirect");
    idle("t1_flush");
    idle("t1_idle");

    applyStimulus("t2_hit", 1, 0, '0, 1, 5'd5, 5'd0, 5'd5);
    idle("t2_stall");
    idle("t2_run");

    applyStimulus("t3_rdx0", 1, 0, '0, 1, 5'd0, 5'd0, 5'd3);
    applyStimulus("t3_novalid", 0, 0, '0, 1, 5'd5, 5'd5, 5'd0);
    applyStimulus("t3_noload", 1, 0, '0, 0, 5'd5, 5'd5, 5'd5);

    applyStimulus("t4_both", 1, 1, 32'h0000_0080, 1, 5'd5, 5'd5, 5'd0);
    applyStimulus("t4_redirect_hit", 1, 0, '0, 1, 5'd7, 5'd7, 5'd0);
    applyStimulus("t4_flush_br", 1, 1, 32'h0000_0100, 1, 5'd7, 5'd0, 5'd7);
    idle("t4_run");
    applyStimulus("t4_stall_then_br", 1, 0, '0, 1, 5'd2, 5'd2, 5'd2);
    applyStimulus("t4_br_in_stall", 1, 1, 32'h0000_0180, 0, 5'd0, 5'd0, 5'd0);
    idle("t4_redirect2");
    idle("t4_flush2");
    idle("t4_idle2");

    applyStimulus("t5_branch", 1, 1, 32'h0000_0200, 0, 5'd0, 5'd0, 5'd0);
    idle("t5_redirect");
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checkReset("t5_async");
    resetModel();
    #20;
    @(posedge clk); #3;
    reset_n = 1'b1;
    applyStimulus("t5_rebranch", 1, 1, 32'h0000_0300, 0, 5'd0, 5'd0, 5'd0);
    idle("t5_redirect2");
    idle("t5_flush2");
    idle("t5_idle2");

    for (int i = 0; i < 17; i++) begin
      applyStimulus("t6_branch", 1, 1, 32'h0000_1000 + XLEN'(i * 4), 0, 5'd0, 5'd0, 5'd0);
      for (int k = 0; k < FLUSH_CYCLES; k++) idle("t6_flush");
    end
    idle("t6_settle");
    @(negedge clk); #3;
    checkField("t6_sat", "flush_cnt", XLEN'(bus.flush_cnt),
               statsOn ? XLEN'((1 << CNT_W) - 1) : '0);

    for (int i = 0; i < 1500; i++) begin
      rTgt = XLEN'($urandom()) & ~XLEN'(3);
      applyStimulus("rand", ($urandom_range(0, 9) < 8), ($urandom_range(0, 6) == 0), rTgt,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
